dmem_wait_ctrl: RTL and testbench
=================================

# dmem_wait_ctrl

Parametrised data-memory block with a request/ready handshake, configurable wait states, byte-lane write enables and alignment/range error reporting. It sits between the MIPS core's load/store port and an internal word array, replacing the fixed single-cycle data RAM. A memory access can therefore take a fixed number of cycles, and the pipeline stalls on `busy`. Misaligned and out-of-range accesses are reported instead of silently aliasing.

## Interface

Parameters:
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `ADDR_W`, 10: byte-address width.
- `DEPTH`, 256: number of words stored.
- `WAIT`, 2: wait-state cycles inserted between acceptance and response; valid range 0..15.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `req`, in, 1: access request; the requester holds it and all request fields stable until `ready`.
- `we`, in, 1: 1 = write, 0 = read.
- `be`, in, DATA_W/8: byte-lane write enables; `be[i]` covers `wdata[8i+7:8i]`.
- `addr`, in, ADDR_W: byte address.
- `wdata`, in, DATA_W: write data.
- `rdata`, out, DATA_W: read data; valid while `ready`=1 for a read, and held until the next successful read.
- `ready`, out, 1: one-cycle completion pulse.
- `busy`, out, 1: high while a transaction is in flight.
- `err`, out, 1: qualified by `ready`; the completed access was misaligned or out of range.

## Operation

- `OFF` = log2(DATA_W/8). The word index is `addr[ADDR_W-1:OFF]`.
- Storage: a DEPTH x DATA_W array. Reset does not clear it.
- States:
  - IDLE: `busy`=0, `ready`=0. When `req`=1, capture `we`, `be`, `addr` and `wdata`. Go to WAIT if WAIT>0 and load the counter with WAIT-1; go to RESP if WAIT=0.
  - WAIT: `busy`=1. The counter decrements each cycle. When the counter reaches 0, go to RESP.
  - RESP: `busy`=1, `ready`=1 for exactly one cycle, then go to IDLE.
- The counter width is clog2(WAIT+1), with a minimum of 1.
- Error detection:
  - `err` is set when `addr[OFF-1:0]` != 0 or when the word index >= DEPTH.
  - On error: no array write, `rdata` unchanged, `ready` still pulses, `err`=1 in the `ready` cycle.
- Write:
  - Performed on the edge that enters RESP.
  - Only lanes with `be[i]`=1 are updated.
  - `be`=0 is a legal no-op that still completes.
  - `rdata` is not changed by a write.
- Read:
  - `rdata` is loaded from the array on the edge that enters RESP.
  - A read that follows a write to the same word returns the written lanes merged with the old lanes.
- Outside the IDLE state, changes to `req` and the request fields are ignored; the captured copies are used.
- Reset (async, any state): state goes to IDLE and the counter to 0. `ready`=0, `busy`=0, `err`=0, `rdata`=0. Any in-flight write is dropped.

## Timing

- A request is accepted in cycle N (IDLE with `req`=1). `ready` is high in cycle N+1+WAIT. `busy` is high in cycles N+1 .. N+1+WAIT.
- With WAIT=0, `ready` is high in cycle N+1.
- IDLE follows the `ready` cycle. The earliest next acceptance is cycle N+2+WAIT, so back-to-back throughput is one access per WAIT+2 cycles.
- `ready`, `busy`, `err` and `rdata` are all registered outputs; there are no combinational paths from the inputs.
- `err` is 0 whenever `ready` is 0.
- Release of `rst` is synchronised by the requester. The first acceptance can occur on the first rising edge with `rst`=1.

## Test plan

- Reset, then WAIT=2. Write `addr`=0x010, `be`=4'hF, `wdata`=0xDEADBEEF accepted at cycle 5 -> `busy` high in cycles 6..8, `ready`=1 only in cycle 8, `err`=0. A read of 0x010 then returns `rdata`=0xDEADBEEF.
- Partial write to 0x010 with `be`=4'b0101 and `wdata`=0x11223344 -> a subsequent read returns 0xDE22BE44.
- Misaligned read of `addr`=0x013 -> `ready` with `err`=1, `rdata` keeps its previous value 0xDE22BE44. Write to `addr`=0x3FC with DEPTH=255 -> `err`=1, and the array is unchanged.
- Build with WAIT=0 -> `ready` in the cycle after acceptance. Holding `req` high continuously gives `ready` every 2 cycles.
- Assert `rst` low during WAIT of a write to 0x020 -> outputs go to 0 immediately. After reset, a read of 0x020 returns the pre-write value, and the FSM is in IDLE.
- Toggle `addr` and `wdata` during WAIT -> the captured values are used; the write lands at the originally presented address.

Source files
------------

// File: rtl/dmem_wait_ctrl.sv
// Data memory with request/ready handshake, fixed wait states, byte-lane writes and
// alignment/range error reporting.
module dmem_wait_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256,
    parameter int WAIT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                busy,
    output logic                err
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int CW  = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              we_q;
    logic [NB-1:0]     be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              bad_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fire;
    logic              acc_we;
    logic              acc_bad;
    logic [NB-1:0]     acc_be;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [MW-1:0]     acc_idx;
    logic              req_bad;

    function automatic logic bad_addr(input logic [ADDR_W-1:0] a);
        return ((a & ADDR_W'(NB - 1)) != '0) || (int'(a >> OFF) >= DEPTH);
    endfunction

    assign req_bad = bad_addr(addr);

    // The array access happens on the edge that enters RESP; with no wait states that
    // edge is the acceptance edge, so the live request fields are used directly.
    always_comb begin
        fire      = 1'b0;
        acc_we    = we_q;
        acc_bad   = bad_q;
        acc_be    = be_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (WAIT == 0) begin
            fire      = (state_q == StIdle) && req;
            acc_we    = we;
            acc_bad   = req_bad;
            acc_be    = be;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else begin
            fire = (state_q == StWait) && (cnt_q == '0);
        end
        acc_idx = acc_addr[OFF +: MW];
    end

    always_ff @(posedge clk) begin
        if (fire && acc_we && !acc_bad) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (fire && !acc_we && !acc_bad) rdata <= mem[acc_idx];
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        be_q    <= be;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        bad_q   <= req_bad;
                        busy    <= 1'b1;
                        if (WAIT == 0) begin
                            state_q <= StResp;
                            ready   <= 1'b1;
                            err     <= req_bad;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CW'((WAIT > 0) ? WAIT - 1 : 0);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StResp;
                        ready   <= 1'b1;
                        err     <= bad_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: two builds (WAIT=2/DEPTH=256 and WAIT=0/DEPTH=255) checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_dmem_wait_ctrl;

    logic        clk;
    logic        rst;
    logic        req_s  [2];
    logic        we_s   [2];
    logic [3:0]  be_s   [2];
    logic [9:0]  addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rd_w   [2];
    logic        rdy_w  [2];
    logic        bsy_w  [2];
    logic        err_w  [2];

    int checks;
    int failures;
    int cyc;

    // Transaction-level model state, one slot per DUT.
    int          acc    [2];
    int          resp   [2];
    logic        m_we   [2];
    logic        m_err  [2];
    logic [3:0]  m_be   [2];
    logic [9:0]  m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] mmem   [2][256];
    bit          mval   [2][256];
    logic [31:0] exp_rd [2];
    bit          rd_known [2];

    dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT(2)) dut0 (
        .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .be(be_s[0]),
        .addr(addr_s[0]), .wdata(wd_s[0]), .rdata(rd_w[0]), .ready(rdy_w[0]),
        .busy(bsy_w[0]), .err(err_w[0])
    );

    dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(255), .WAIT(0)) dut1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .be(be_s[1]),
        .addr(addr_s[1]), .wdata(wd_s[1]), .rdata(rd_w[1]), .ready(rdy_w[1]),
        .busy(bsy_w[1]), .err(err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 255;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc[k]      = -100;
            resp[k]     = -100;
            exp_rd[k]   = '0;
            rd_known[k] = 1'b1;
        end
    endtask

    // Called right after each rising edge, with the inputs of the cycle that just ended.
    task automatic model_update();
        int idx;
        if (!rst) begin
            model_reset();
            cyc++;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (cyc > resp[k] && req_s[k]) begin
                m_we[k]   = we_s[k];
                m_be[k]   = be_s[k];
                m_addr[k] = addr_s[k];
                m_wd[k]   = wd_s[k];
                m_err[k]  = (addr_s[k][1:0] != 2'b00) || (int'(addr_s[k] >> 2) >= depth_of(k));
                acc[k]    = cyc;
                resp[k]   = cyc + 1 + wait_of(k);
            end
        end
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (cyc == resp[k] && !m_err[k]) begin
                idx = int'(m_addr[k] >> 2);
                if (m_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[k][b]) mmem[k][idx][8*b +: 8] = m_wd[k][8*b +: 8];
                    mval[k][idx] = mval[k][idx] || (m_be[k] == 4'hF);
                end else begin
                    exp_rd[k]   = mmem[k][idx];
                    rd_known[k] = mval[k][idx];
                end
            end
        end
    endtask

    task automatic compare();
        logic exp_busy;
        logic exp_ready;
        for (int k = 0; k < 2; k++) begin
            exp_busy  = (cyc > acc[k]) && (cyc <= resp[k]);
            exp_ready = (cyc == resp[k]);
            check("busy", k, 32'(bsy_w[k]), 32'(exp_busy));
            check("ready", k, 32'(rdy_w[k]), 32'(exp_ready));
            check("err", k, 32'(err_w[k]), 32'(exp_ready && m_err[k]));
            if (rd_known[k]) check("rdata", k, rd_w[k], exp_rd[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic access(input int k, input logic w, input logic [3:0] b,
                          input logic [9:0] a, input logic [31:0] d, input bit toggle,
                          output int lat, output int bcnt, output logic e,
                          output logic [31:0] rd);
        int t0;
        req_s[k] = 1'b1; we_s[k] = w; be_s[k] = b; addr_s[k] = a; wd_s[k] = d;
        t0 = cyc; lat = -1; bcnt = 0; e = 1'b0; rd = '0;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            tick();
            if (bsy_w[k]) bcnt++;
            if (rdy_w[k]) begin
                lat = cyc - t0;
                e   = err_w[k];
                rd  = rd_w[k];
            end else if (toggle && bsy_w[k]) begin
                addr_s[k] = addr_s[k] ^ 10'h004;
                wd_s[k]   = ~wd_s[k];
            end
        end
        req_s[k] = 1'b0;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut%0d: got no ready want ready within 40 cycles", k);
        end
        tick();
    endtask

    int          lat;
    int          bc;
    logic        e;
    logic [31:0] rd;
    int          nrdy;
    int          nadj;
    logic        prev_rdy;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; be_s[k] = '0; addr_s[k] = '0; wd_s[k] = '0;
            for (int i = 0; i < 256; i++) mval[k][i] = 1'b0;
        end
        model_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", k, 32'(bsy_w[k]), 32'd0);
            check("rst_ready", k, 32'(rdy_w[k]), 32'd0);
            check("rst_err", k, 32'(err_w[k]), 32'd0);
            check("rst_rdata", k, rd_w[k], 32'd0);
        end
        tick(); tick();
        rst = 1'b1;

        // Full write, then read back.
        access(0, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, 1'b0, lat, bc, e, rd);
        check("wr_latency", 0, 32'(lat), 32'd3);
        check("wr_busy_cycles", 0, 32'(bc), 32'd3);
        check("wr_err", 0, 32'(e), 32'd0);
        access(0, 1'b0, 4'h0, 10'h010, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd_full", 0, rd, 32'hDEADBEEF);

        // Partial-lane merge.
        access(0, 1'b1, 4'b0101, 10'h010, 32'h11223344, 1'b0, lat, bc, e, rd);
        access(0, 1'b0, 4'h0, 10'h010, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd_merge", 0, rd, 32'hDE22BE44);

        // Misaligned read keeps rdata.
        access(0, 1'b0, 4'h0, 10'h013, 32'h0, 1'b0, lat, bc, e, rd);
        check("misalign_err", 0, 32'(e), 32'd1);
        check("misalign_rdata", 0, rd, 32'hDE22BE44);

        // Captured fields are used while inputs wander during WAIT.
        access(0, 1'b1, 4'hF, 10'h020, 32'hCAFEF00D, 1'b0, lat, bc, e, rd);
        access(0, 1'b1, 4'hF, 10'h044, 32'h01010101, 1'b0, lat, bc, e, rd);
        access(0, 1'b1, 4'hF, 10'h040, 32'hA5A5A5A5, 1'b1, lat, bc, e, rd);
        access(0, 1'b0, 4'h0, 10'h040, 32'h0, 1'b0, lat, bc, e, rd);
        check("toggle_target", 0, rd, 32'hA5A5A5A5);
        access(0, 1'b0, 4'h0, 10'h044, 32'h0, 1'b0, lat, bc, e, rd);
        check("toggle_neighbour", 0, rd, 32'h01010101);

        // Reset during WAIT of a write drops the write.
        req_s[0] = 1'b1; we_s[0] = 1'b1; be_s[0] = 4'hF; addr_s[0] = 10'h020;
        wd_s[0] = 32'h12345678;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("midrst_busy", 0, 32'(bsy_w[0]), 32'd0);
        check("midrst_ready", 0, 32'(rdy_w[0]), 32'd0);
        check("midrst_err", 0, 32'(err_w[0]), 32'd0);
        check("midrst_rdata", 0, rd_w[0], 32'd0);
        model_reset();
        req_s[0] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        access(0, 1'b0, 4'h0, 10'h020, 32'h0, 1'b0, lat, bc, e, rd);
        check("postrst_latency", 0, 32'(lat), 32'd3);
        check("postrst_rdata", 0, rd, 32'hCAFEF00D);

        // WAIT=0, DEPTH=255 build: range error and single-cycle latency.
        access(1, 1'b1, 4'hF, 10'h3F8, 32'h0BADF00D, 1'b0, lat, bc, e, rd);
        check("w0_latency", 1, 32'(lat), 32'd1);
        check("w0_err", 1, 32'(e), 32'd0);
        access(1, 1'b1, 4'hF, 10'h3FC, 32'hFFFFFFFF, 1'b0, lat, bc, e, rd);
        check("range_wr_err", 1, 32'(e), 32'd1);
        access(1, 1'b0, 4'h0, 10'h3F8, 32'h0, 1'b0, lat, bc, e, rd);
        check("range_neighbour", 1, rd, 32'h0BADF00D);
        access(1, 1'b0, 4'h0, 10'h3FC, 32'h0, 1'b0, lat, bc, e, rd);
        check("range_rd_err", 1, 32'(e), 32'd1);
        check("range_rd_rdata", 1, rd, 32'h0BADF00D);

        // Request held high: one completion every two cycles.
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 10'h3F8;
        nrdy = 0; nadj = 0; prev_rdy = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (rdy_w[1]) nrdy++;
            if (rdy_w[1] && prev_rdy) nadj++;
            prev_rdy = rdy_w[1];
        end
        req_s[1] = 1'b0;
        tick();
        check("b2b_readies", 1, 32'(nrdy), 32'd4);
        check("b2b_adjacent", 1, 32'(nadj), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
